// File: rtl/dut_cmd_sequencer_if.sv
// Bus bundle between the command sequencer and its surroundings: DI_FIFO read side,
// DUT response, stimulus/result FIFO status, configuration outputs and status flags.
interface dut_cmd_sequencer_if #(
    parameter int unsigned STF_WIDTH = 24,
    parameter int unsigned RTF_WIDTH = 24,
    parameter int unsigned DIF_WIDTH = 32
);
    logic [DIF_WIDTH-1:0] dififo_data;
    logic                 dififo_rdempty;
    logic                 dififo_rdreq;
    logic [RTF_WIDTH-1:0] miso_data;
    logic                 sfifo_rdempty;
    logic                 rfifo_wrfull;
    logic                 stim_en;
    logic [STF_WIDTH-1:0] mux_config;
    logic [STF_WIDTH-1:0] trigger_mask;
    logic                 busy;
    logic                 trig_timeout;
    logic                 bad_cmd;
    logic                 clr_status;

    // Sequencer side
    modport master (
        input  dififo_data, dififo_rdempty, miso_data, sfifo_rdempty, rfifo_wrfull, clr_status,
        output dififo_rdreq, stim_en, mux_config, trigger_mask, busy, trig_timeout, bad_cmd
    );

    // Environment side
    modport slave (
        output dififo_data, dififo_rdempty, miso_data, sfifo_rdempty, rfifo_wrfull, clr_status,
        input  dififo_rdreq, stim_en, mux_config, trigger_mask, busy, trig_timeout, bad_cmd
    );
endinterface

// File: rtl/dut_cmd_sequencer.sv
// Command sequencer: pops command words from DI_FIFO, configures the pin mux and
// trigger mask, times delays, waits for DUT triggers and meters stimulus vectors.
module dut_cmd_sequencer #(
    parameter int unsigned STF_WIDTH = 24,
    parameter int unsigned RTF_WIDTH = 24,
    parameter int unsigned REQ_WIDTH = 3,
    parameter int unsigned CMD_WIDTH = 5,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned DIF_WIDTH = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
) (
    input logic                  clock,
    input logic                  reset_n,
    dut_cmd_sequencer_if.master  io_bus
);
    localparam int unsigned OP_WIDTH = REQ_WIDTH + CMD_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_NOP       = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SETUP_MUX = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_DELAY     = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_TRGMASK   = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_WAIT_TRIG = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_RUN       = OP_WIDTH'(5);

    typedef enum logic [2:0] {
        StIdle,
        StReadCmd,
        StDelay,
        StWaitTrig,
        StRun
    } state_e;

    state_e               r_state;
    // Shared counter: DELAY/RUN count down from N, WAIT_TRIG counts up from 0
    logic [CNT_WIDTH-1:0] r_cnt;
    // Timeout limit captured at decode; the FIFO word may change once we leave READ_CMD
    logic [CNT_WIDTH-1:0] r_arg;
    logic [STF_WIDTH-1:0] r_mux_config;
    logic [STF_WIDTH-1:0] r_trigger_mask;
    logic                 r_trig_timeout;
    logic                 r_bad_cmd;

    logic [OP_WIDTH-1:0]  w_opcode;
    logic [STF_WIDTH-1:0] w_arg;
    logic [CNT_WIDTH-1:0] w_arg_cnt;
    logic                 w_pop;
    logic                 w_hit;
    logic                 w_expire;
    logic                 w_stim_en;
    logic                 w_set_bad;
    logic                 w_set_timeout;

    assign w_opcode  = io_bus.dififo_data[DIF_WIDTH-1 -: OP_WIDTH];
    assign w_arg     = io_bus.dififo_data[STF_WIDTH-1:0];
    assign w_arg_cnt = w_arg[CNT_WIDTH-1:0];

    // reset_n gates the combinational strobes so nothing leaks out while reset is held
    assign w_pop     = reset_n && (r_state == StIdle) && !io_bus.dififo_rdempty;
    assign w_stim_en = reset_n && (r_state == StRun) && !io_bus.sfifo_rdempty
                       && !io_bus.rfifo_wrfull;
    assign w_hit     = |(io_bus.miso_data & r_trigger_mask[RTF_WIDTH-1:0]);
    // arg==0 never expires (wait forever)
    assign w_expire  = (r_arg != '0) && (r_cnt == (r_arg - CNT_WIDTH'(1)));

    // Flag set conditions: bad opcode or WAIT_TRIG with nothing to trigger on; timeout loses to hit
    always_comb begin
        w_set_bad     = 1'b0;
        w_set_timeout = (r_state == StWaitTrig) && !w_hit && w_expire;
        if (r_state == StReadCmd) begin
            case (w_opcode)
                OP_NOP, OP_SETUP_MUX, OP_DELAY, OP_TRGMASK, OP_RUN: w_set_bad = 1'b0;
                OP_WAIT_TRIG: w_set_bad = (r_trigger_mask == '0);
                default:      w_set_bad = 1'b1;
            endcase
        end
    end

    // Command FSM with registered configuration outputs and sticky status flags
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_arg          <= '0;
            r_mux_config   <= '0;
            r_trigger_mask <= '0;
            r_trig_timeout <= 1'b0;
            r_bad_cmd      <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_pop) r_state <= StReadCmd;
                end
                StReadCmd: begin
                    r_state <= StIdle;
                    r_arg   <= w_arg_cnt;
                    case (w_opcode)
                        OP_SETUP_MUX: r_mux_config <= w_arg;
                        OP_DELAY: begin
                            r_cnt <= w_arg_cnt;
                            if (w_arg_cnt != '0) r_state <= StDelay;
                        end
                        OP_TRGMASK: r_trigger_mask <= w_arg;
                        OP_WAIT_TRIG: begin
                            r_cnt <= '0;
                            if (r_trigger_mask != '0) r_state <= StWaitTrig;
                        end
                        OP_RUN: begin
                            r_cnt <= w_arg_cnt;
                            if (w_arg_cnt != '0) r_state <= StRun;
                        end
                        default: r_state <= StIdle;
                    endcase
                end
                StDelay: begin
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == CNT_WIDTH'(1)) r_state <= StIdle;
                end
                StWaitTrig: begin
                    if (w_hit || w_expire) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                StRun: begin
                    // Stalls simply hold; only granted vectors consume the count
                    if (w_stim_en) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                        if (r_cnt == CNT_WIDTH'(1)) r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Set beats a coincident clear
            if (w_set_bad) begin
                r_bad_cmd <= 1'b1;
            end else if (io_bus.clr_status) begin
                r_bad_cmd <= 1'b0;
            end
            if (w_set_timeout) begin
                r_trig_timeout <= 1'b1;
            end else if (io_bus.clr_status) begin
                r_trig_timeout <= 1'b0;
            end
        end
    end

    assign io_bus.dififo_rdreq = w_pop;
    assign io_bus.stim_en      = w_stim_en;
    assign io_bus.mux_config   = r_mux_config;
    assign io_bus.trigger_mask = r_trigger_mask;
    assign io_bus.busy         = (r_state != StIdle);
    assign io_bus.trig_timeout = r_trig_timeout;
    assign io_bus.bad_cmd      = r_bad_cmd;

endmodule
